// File: rtl/dmro_frame_rx.sv
// dmro_frame_rx: recovers 30-bit payloads from the MSB-first 32-bit DMRO frame stream
// using a bit-slip hunt, multi-frame header check and locked tracking with error counting.
module dmro_frame_rx #(
  parameter logic [1:0] HEADER   = 2'b10,
  parameter int         LOCK_N   = 4,
  parameter int         UNLOCK_M = 4,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sin,
  input  logic             clr_cnt,
  output logic [29:0]      dout,
  output logic             dvalid,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam int BW = $clog2(UNLOCK_M + 1);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t          state, state_n;
  logic [30:0]     sr;
  logic [4:0]      cnt, cnt_n;
  logic [GW-1:0]   good_cnt, good_n, good_inc;
  logic [BW-1:0]   bad_cnt, bad_n, bad_inc;
  logic [31:0]     frame;
  logic            bnd, hdr_ok, emit, err;
  assign frame    = {sr, sin};
  assign bnd      = cnt == 5'd31;
  assign hdr_ok   = frame[31:30] == HEADER;
  assign good_inc = good_cnt + 1'b1;
  assign bad_inc  = bad_cnt + 1'b1;
  // Holding cnt at 31 after a rejected boundary slips the frame window by one bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 5'd1;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    emit    = 1'b0;
    err     = 1'b0;
    if (!en) begin
      state_n = HUNT;
      cnt_n   = 5'd0;
      good_n  = '0;
      bad_n   = '0;
    end else if (bnd) begin
      case (state)
        HUNT: begin
          if (hdr_ok) begin
            good_n  = GW'(1);
            bad_n   = '0;
            state_n = (LOCK_N == 1) ? LOCKED : CHECK;
          end else cnt_n = 5'd31;
        end
        CHECK: begin
          if (hdr_ok) begin
            good_n = good_inc;
            if (good_inc == GW'(LOCK_N)) begin
              state_n = LOCKED;
              bad_n   = '0;
            end
          end else begin
            state_n = HUNT;
            cnt_n   = 5'd31;
          end
        end
        LOCKED: begin
          if (hdr_ok) begin
            emit  = 1'b1;
            bad_n = '0;
          end else begin
            err   = 1'b1;
            bad_n = bad_inc;
            if (bad_inc == BW'(UNLOCK_M)) begin
              state_n = HUNT;
              cnt_n   = 5'd31;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= HUNT;
      sr        <= '0;
      cnt       <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      dout      <= '0;
      dvalid    <= 1'b0;
      locked    <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      sr        <= {sr[29:0], sin};
      state     <= state_n;
      cnt       <= cnt_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      dvalid    <= emit;
      locked    <= state_n == LOCKED;
      if (emit) dout <= frame[29:0];
      frame_cnt <= clr_cnt ? '0 : emit ? frame_cnt + 1'b1 : frame_cnt;
      err_cnt   <= clr_cnt ? '0 : (err && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    end
  end
endmodule

// File: tb/tb_dmro_frame_rx.sv
// tb_dmro_frame_rx: randomized frame streams against a bit-index reference model, with a
// scoreboard monitor; a second instance with 4-bit counters exercises saturation.
module tb_dmro_frame_rx;
  localparam int LOCK_N = 4, UNLOCK_M = 4;
  logic clk = 0, rstn = 0, en = 1, sin = 0, clr_cnt = 0;
  logic [29:0] dout, dout4;
  logic dvalid, dvalid4, locked, locked4;
  logic [15:0] frame_cnt, err_cnt;
  logic [3:0] frame_cnt4, err_cnt4;
  int vectors = 0, miscompares = 0;
  dmro_frame_rx #(.HEADER(2'b10), .LOCK_N(LOCK_N), .UNLOCK_M(UNLOCK_M), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .en(en), .sin(sin), .clr_cnt(clr_cnt), .dout(dout),
    .dvalid(dvalid), .locked(locked), .frame_cnt(frame_cnt), .err_cnt(err_cnt));
  dmro_frame_rx #(.HEADER(2'b10), .LOCK_N(LOCK_N), .UNLOCK_M(UNLOCK_M), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .en(en), .sin(sin), .clr_cnt(clr_cnt), .dout(dout4),
    .dvalid(dvalid4), .locked(locked4), .frame_cnt(frame_cnt4), .err_cnt(err_cnt4));
  always #5 clk = ~clk;
  // Reference model: e counts enabled edges, nb is the edge index of the next frame boundary.
  logic [31:0] hist;
  int e, nb, good_run, bad_run;
  bit m_lk, exp_dv;
  logic [15:0] exp_fc, exp_err;
  logic [3:0] exp_err4;
  logic [29:0] sb[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist = 0; e = 0; nb = 31; good_run = 0; bad_run = 0; m_lk = 0; exp_dv = 0;
    exp_fc = 0; exp_err = 0; exp_err4 = 0;
    sb.delete();
  endtask
  task automatic model_edge(input logic b, input logic c);
    bit emit = 0, bad = 0;
    hist = {hist[30:0], b};
    if (!en) begin
      e = 0; nb = 31; good_run = 0; bad_run = 0; m_lk = 0;
    end else begin
      if (e == nb) begin
        if (hist[31:30] == 2'b10) begin
          if (m_lk) begin emit = 1; bad_run = 0; end
          else begin
            good_run++;
            if (good_run >= LOCK_N) begin m_lk = 1; bad_run = 0; end
          end
          nb = e + 32;
        end else if (m_lk) begin
          bad = 1; bad_run++;
          if (bad_run >= UNLOCK_M) begin m_lk = 0; good_run = 0; nb = e + 1; end
          else nb = e + 32;
        end else begin
          good_run = 0; nb = e + 1;
        end
      end
      e++;
    end
    exp_dv = emit;
    if (emit) begin sb.push_back(hist[29:0]); exp_fc++; end
    if (bad) begin
      if (exp_err != 16'hFFFF) exp_err++;
      if (exp_err4 != 4'hF) exp_err4++;
    end
    if (c) begin exp_fc = 0; exp_err = 0; exp_err4 = 0; end
  endtask
  task automatic step(input logic b, input logic c = 1'b0);
    sin = b; clr_cnt = c;
    @(posedge clk); #1;
    if (rstn) model_edge(b, c);
    clr_cnt = 0;
  endtask
  task automatic send_frame(input logic [1:0] h, input logic [29:0] pl, input logic c = 1'b0);
    logic [31:0] f;
    f = {h, pl};
    for (int i = 31; i >= 0; i--) step(f[i], (i == 0) ? c : 1'b0);
  endtask
  function automatic logic [1:0] bad_hdr();
    int r;
    r = $urandom_range(0, 2);
    return (r == 2) ? 2'b11 : 2'(r);
  endfunction
  task automatic do_reset();
    #2 rstn = 0;
    model_reset();
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    repeat (3) step(1'($urandom));
    rstn = 1;
  endtask
  always @(negedge clk) begin
    logic [29:0] x;
    chk("dvalid", dvalid, exp_dv);
    chk("dvalid4", dvalid4, exp_dv);
    if (dvalid) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dout_unexpected: got dvalid with dout %0h, expected no word", dout);
      end else begin
        x = sb.pop_front();
        chk("dout", dout, x);
        chk("dout4", dout4, x);
      end
    end
    chk("locked", locked, m_lk);
    chk("locked4", locked4, m_lk);
    chk("frame_cnt", frame_cnt, exp_fc);
    chk("err_cnt", err_cnt, exp_err);
    chk("frame_cnt4", frame_cnt4, exp_fc[3:0]);
    chk("err_cnt4", err_cnt4, exp_err4);
  end
  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    repeat (5) step(1'($urandom));
    repeat (8) send_frame(2'b10, 30'h1234_5678);
    send_frame(2'b01, 30'($urandom));
    repeat (3) send_frame(2'b10, 30'($urandom));
    repeat (4) send_frame(bad_hdr(), 30'($urandom));
    repeat (10) send_frame(2'b10, 30'($urandom));
    send_frame(2'b00, 30'($urandom), 1'b1);
    repeat (2) send_frame(2'b10, 30'($urandom));
    send_frame(2'b10, 30'($urandom), 1'b1);
    repeat (10) send_frame(2'b10, 30'($urandom));
    for (int i = 31; i > 21; i--) step(1'($urandom));
    do_reset();
    repeat (12) send_frame(2'b10, 30'($urandom));
    repeat (20) begin
      send_frame(bad_hdr(), 30'($urandom));
      send_frame(2'b10, 30'($urandom));
    end
    en = 0;
    repeat (8) step(1'($urandom));
    en = 1;
    repeat (10) send_frame(2'b10, 30'($urandom));
    repeat (200) begin
      r = $urandom_range(0, 99);
      if (r < 5) repeat ($urandom_range(1, 5)) step(1'($urandom));
      else if (r < 6) begin
        en = 0;
        repeat ($urandom_range(3, 8)) step(1'($urandom));
        en = 1;
      end else if (r < 20) send_frame(bad_hdr(), 30'($urandom), 1'($urandom_range(0, 99) < 3));
      else send_frame(2'b10, 30'($urandom), 1'($urandom_range(0, 99) < 3));
    end
    @(negedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
